// File: rtl/tetris_pkg.sv
// tetris_pkg: field geometry, placer states and shape-row helpers shared by the placer.
package tetris_pkg;
  localparam int ROWS = 25;
  localparam int COLS = 10;
  localparam int ADDR_W = 5;
  typedef enum logic [3:0] {INIT, IDLE, CHECK, DROP, MERGE, COMPACT, FILL, WRITE, DONE} state_t;
  function automatic logic [3:0] shape_row(input logic [15:0] s, input logic [1:0] r);
    return s[{r, 2'b00} +: 4];
  endfunction
  function automatic logic [19:0] shift_row(input logic [3:0] row, input logic [3:0] x);
    return 20'(row) << x;
  endfunction
endpackage

// File: rtl/piece_placer_if.sv
// piece_placer_if: placement request, status and field write-out port of the piece placer.
interface piece_placer_if;
  import tetris_pkg::*;
  logic place;
  logic [63:0] shape;
  logic [3:0] best_x;
  logic [1:0] best_i;
  logic busy;
  logic done;
  logic [2:0] lines_cleared;
  logic error;
  logic game_over;
  logic [ADDR_W-1:0] fld_write_addr;
  logic [COLS-1:0] fld_write_data;
  logic fld_write_enable;
  modport master(output place, shape, best_x, best_i,
                 input busy, done, lines_cleared, error, game_over, fld_write_addr, fld_write_data, fld_write_enable);
  modport slave(input place, shape, best_x, best_i,
                output busy, done, lines_cleared, error, game_over, fld_write_addr, fld_write_data, fld_write_enable);
endinterface

// File: rtl/shape_fit.sv
// shape_fit: tests a 4x4 shape at (x, y) against the four field rows under it.
module shape_fit
  import tetris_pkg::*;
(
  input  logic [15:0]       shape,
  input  logic [3:0]        x,
  input  logic [ADDR_W-1:0] y,
  input  logic [COLS-1:0]   rows [4],
  output logic              collide,
  output logic              out_of_bounds
);
  logic [19:0] w;
  always_comb begin
    collide = 1'b0;
    out_of_bounds = 1'b0;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      w = shift_row(shape_row(shape, 2'(r)), x);
      collide |= |(w[COLS-1:0] & rows[r]);
      out_of_bounds |= (|w[19:COLS]) | ((|w) & (6'(y) + 6'(r) >= 6'(ROWS)));
    end
  end
endmodule

// File: rtl/piece_placer.sv
// piece_placer: hard-drops a piece into a shadow field, clears full lines and streams the field out.
module piece_placer
  import tetris_pkg::*;
(
  input logic clk,
  input logic rst_n,
  piece_placer_if.slave bus
);
  state_t state, state_nx;
  logic [COLS-1:0] field [ROWS];
  logic [15:0] shp;
  logic [3:0] x;
  logic [ADDR_W-1:0] y, cnt, src, dst, waddr;
  logic [2:0] lines;
  logic error, game_over, busy, done, we;
  logic [COLS-1:0] wdata;
  logic [5:0] ry [4];
  logic [COLS-1:0] frow [4];
  logic [19:0] sh [4];
  logic collide, oob, accept, reject, hit, full;
  for (genvar g = 0; g < 4; g++) begin : g_row
    assign ry[g] = {1'b0, y} + 6'(g);
    assign frow[g] = ry[g] < 6'(ROWS) ? field[ry[g][ADDR_W-1:0]] : '0;
    assign sh[g] = shift_row(shape_row(shp, 2'(g)), x);
  end
  shape_fit u_fit (
    .shape(shp), .x(x), .y(y), .rows(frow), .collide(collide), .out_of_bounds(oob)
  );
  assign accept = bus.place && !game_over;
  assign reject = shp == '0 || oob;
  assign hit = collide || oob;
  assign full = &field[src];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      INIT:    state_nx = cnt == ADDR_W'(ROWS - 1) ? IDLE : INIT;
      IDLE:    state_nx = accept ? CHECK : IDLE;
      CHECK:   state_nx = reject ? DONE : DROP;
      DROP:    state_nx = !hit ? DROP : y == '0 ? DONE : MERGE;
      MERGE:   state_nx = COMPACT;
      COMPACT: state_nx = src != '0 ? COMPACT : (lines == '0 && !full) ? WRITE : FILL;
      FILL:    state_nx = dst == '0 ? WRITE : FILL;
      WRITE:   state_nx = cnt == ADDR_W'(ROWS - 1) ? DONE : WRITE;
      DONE:    state_nx = IDLE;
      default: state_nx = INIT;
    endcase
  end
  // Compaction copies downward in place: dst never rises above src, so unread rows stay intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) field[i] <= '0;
      shp <= '0;
      x <= '0;
      y <= '0;
      cnt <= '0;
      src <= '0;
      dst <= '0;
      lines <= '0;
      error <= 1'b0;
      game_over <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      we <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      case (state)
        INIT, WRITE: cnt <= cnt == ADDR_W'(ROWS - 1) ? '0 : cnt + 1'b1;
        IDLE: if (accept) begin
          shp <= bus.shape[{bus.best_i, 4'b0000} +: 16];
          x <= bus.best_x;
          y <= '0;
          error <= 1'b0;
          lines <= '0;
        end
        CHECK: if (reject) error <= 1'b1;
        DROP: if (!hit) y <= y + 1'b1;
        else if (y == '0) game_over <= 1'b1;
        else y <= y - 1'b1;
        MERGE: begin
          for (int r = 0; r < 4; r++)
            if (ry[r] < 6'(ROWS)) field[ry[r][ADDR_W-1:0]] <= frow[r] | sh[r][COLS-1:0];
          src <= ADDR_W'(ROWS - 1);
          dst <= ADDR_W'(ROWS - 1);
        end
        COMPACT: begin
          if (full) lines <= lines + 3'd1;
          else begin
            field[dst] <= field[src];
            dst <= dst - 1'b1;
          end
          src <= src - 1'b1;
        end
        FILL: begin
          field[dst] <= '0;
          dst <= dst - 1'b1;
        end
        default: ;
      endcase
      busy <= !(state inside {IDLE, DONE});
      done <= state == DONE;
      we <= state == INIT || state == WRITE;
      waddr <= cnt;
      wdata <= state == WRITE ? field[cnt] : '0;
    end
  end
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.lines_cleared = lines;
  assign bus.error = error;
  assign bus.game_over = game_over;
  assign bus.fld_write_enable = we;
  assign bus.fld_write_addr = waddr;
  assign bus.fld_write_data = wdata;
endmodule

// File: tb/tb_piece_placer.sv
// tb_piece_placer: directed placements with queued expected write-outs and done status, checked by a monitor.
module tb_piece_placer;
  import tetris_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  piece_placer_if bus();
  piece_placer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct packed {logic [4:0] a; logic [9:0] d;} wr_t;
  wr_t exp_wr[$];
  logic [4:0] exp_done[$];
  logic [9:0] ef [ROWS];
  wr_t we_item;
  logic [4:0] de_item;
  int tests = 0;
  int fails = 0;
  int lat;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.fld_write_enable) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          we_item = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.fld_write_addr), 32'(we_item.a));
          chk($sformatf("wr_data_row%0d", we_item.a), 32'(bus.fld_write_data), 32'(we_item.d));
          chk("wr_busy", 32'(bus.busy), 1);
        end
      end
      if (bus.done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          de_item = exp_done.pop_front();
          chk("done_lines", 32'(bus.lines_cleared), 32'(de_item[4:2]));
          chk("done_error", 32'(bus.error), 32'(de_item[1]));
          chk("done_game_over", 32'(bus.game_over), 32'(de_item[0]));
          chk("done_busy", 32'(bus.busy), 0);
        end
      end
    end
  end
  task automatic push_field();
    for (int i = 0; i < ROWS; i++) exp_wr.push_back({5'(i), ef[i]});
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_lines"}, 32'(bus.lines_cleared), 0);
    chk({tag, "_error"}, 32'(bus.error), 0);
    chk({tag, "_game_over"}, 32'(bus.game_over), 0);
    chk({tag, "_we"}, 32'(bus.fld_write_enable), 0);
    chk({tag, "_addr"}, 32'(bus.fld_write_addr), 0);
    chk({tag, "_data"}, 32'(bus.fld_write_data), 0);
  endtask
  task automatic init_sweep();
    int bc = 0;
    exp_wr.delete();
    exp_done.delete();
    for (int i = 0; i < ROWS; i++) ef[i] = '0;
    push_field();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.busy) bc++;
    end
    chk("init_busy_cycles", 32'(bc), 25);
    chk("init_writes_left", 32'(exp_wr.size()), 0);
  endtask
  task automatic fire(input logic [15:0] s, input logic [3:0] x, input logic [1:0] ri);
    int n = 0;
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("idle_timeout", 1, 0);
    bus.shape = {4{16'hFFFF}};
    bus.shape[{ri, 4'b0000} +: 16] = s;
    bus.best_x = x;
    bus.best_i = ri;
    bus.place = 1'b1;
    @(negedge clk);
    bus.place = 1'b0;
  endtask
  task automatic wait_done(output int l);
    l = 1;
    while (!bus.done && l < 300) begin
      @(negedge clk);
      l++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask
  task automatic place_piece(input logic [15:0] s, input logic [3:0] x, input logic [1:0] ri, input int exp_lat);
    int l;
    fire(s, x, ri);
    wait_done(l);
    if (exp_lat > 0) chk("latency", 32'(l), 32'(exp_lat));
  endtask
  task automatic watch_idle(input string tag, input int cycles);
    int bc = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.busy) bc++;
    end
    chk(tag, 32'(bc), 0);
  endtask
  initial begin
    bus.place = 1'b0;
    bus.shape = '0;
    bus.best_x = '0;
    bus.best_i = '0;
    #1;
    check_zero("reset");
    init_sweep();
    ef[24] = 10'h00F;
    push_field();
    exp_done.push_back({3'd0, 1'b0, 1'b0});
    place_piece(16'h000F, 4'd0, 2'd0, 80);
    ef[24] = 10'h0FF;
    push_field();
    exp_done.push_back({3'd0, 1'b0, 1'b0});
    place_piece(16'h000F, 4'd4, 2'd1, 0);
    ef[24] = 10'h300;
    ef[23] = 10'h000;
    push_field();
    exp_done.push_back({3'd1, 1'b0, 1'b0});
    place_piece(16'h0033, 4'd8, 2'd2, 80);
    exp_done.push_back({3'd0, 1'b1, 1'b0});
    place_piece(16'h000F, 4'd7, 2'd3, 3);
    ef[24] = 10'h30F;
    push_field();
    exp_done.push_back({3'd0, 1'b0, 1'b0});
    place_piece(16'h000F, 4'd0, 2'd0, 0);
    ef[23] = 10'h00F;
    push_field();
    exp_done.push_back({3'd0, 1'b0, 1'b0});
    fire(16'h000F, 4'd0, 2'd1);
    for (int n = 0; n < 200 && !bus.fld_write_enable; n++) @(negedge clk);
    chk("reached_write", 32'(bus.fld_write_enable), 1);
    repeat (5) @(negedge clk);
    bus.shape = {4{16'h000F}};
    bus.best_x = 4'd2;
    bus.place = 1'b1;
    @(negedge clk);
    bus.place = 1'b0;
    wait_done(lat);
    watch_idle("busy_after_ignored_place", 40);
    chk("wr_queue_after_ignored", 32'(exp_wr.size()), 0);
    fire(16'h000F, 4'd4, 2'd0);
    repeat (34) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("mid_compact_reset");
    init_sweep();
    for (int k = 1; k <= 6; k++) begin
      for (int r = 0; r < 4; r++) ef[25 - 4 * k + r] = 10'h001;
      push_field();
      exp_done.push_back({3'd0, 1'b0, 1'b0});
      place_piece(16'h1111, 4'd0, 2'd2, 0);
    end
    exp_done.push_back({3'd0, 1'b0, 1'b1});
    place_piece(16'h1111, 4'd0, 2'd2, 4);
    fire(16'h000F, 4'd5, 2'd0);
    watch_idle("busy_after_game_over", 60);
    chk("game_over_sticky", 32'(bus.game_over), 1);
    chk("wr_queue_empty", 32'(exp_wr.size()), 0);
    chk("done_queue_empty", 32'(exp_done.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
